// File: rtl/stepper_seq_drv.sv
// Stepper-motor phase sequencer: accepts move commands and steps a PHASES-coil
// one-hot/two-hot drive pattern at a programmable rate while tracking absolute position.
module stepper_seq_drv #(
    parameter int unsigned PHASES = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned POS_W  = 16
) (
    input  logic              drv_clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic              cmd_half,
    input  logic [CNT_W-1:0]  cmd_steps,
    input  logic [DIV_W-1:0]  cmd_period,
    input  logic              abort,
    output logic [PHASES-1:0] motor_drv,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  steps_left,
    output logic [POS_W-1:0]  position
);

    localparam int unsigned NPH  = 2 * PHASES;
    // Two spare codes so ph + 2 never overflows before the modulo correction.
    localparam int unsigned PH_W = $clog2(NPH + 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [PH_W-1:0]    ph;
    logic               dir_q;
    logic               half_q;
    logic [DIV_W-1:0]   period_q;
    logic [DIV_W-1:0]   div;

    logic [PH_W-1:0]    step_mag;
    logic [PH_W-1:0]    ph_sum;
    logic [PH_W-1:0]    ph_next;
    logic [POS_W-1:0]   pos_mag;
    logic [POS_W-1:0]   pos_delta;

    // Coil i is driven by its own full-step index and both neighbouring half-step indices.
    function automatic logic [PHASES-1:0] pat_of(input logic [PH_W-1:0] p);
        logic [PHASES-1:0] res;
        res = '0;
        for (int i = 0; i < int'(PHASES); i++) begin
            res[i] = (p == PH_W'(2 * i)) || (p == PH_W'(2 * i + 1)) ||
                     (p == PH_W'((2 * i + int'(NPH) - 1) % int'(NPH)));
        end
        return res;
    endfunction

    // Next phase index (modulo 2*PHASES, both directions) and signed position delta.
    always_comb begin
        step_mag = half_q ? PH_W'(1) : PH_W'(2);
        ph_sum   = ph + step_mag;
        ph_next  = ph_sum;
        if (dir_q) begin
            if (ph_sum >= PH_W'(NPH)) begin
                ph_next = ph_sum - PH_W'(NPH);
            end
        end else if (ph < step_mag) begin
            ph_next = ph + PH_W'(NPH) - step_mag;
        end else begin
            ph_next = ph - step_mag;
        end
        pos_mag   = half_q ? POS_W'(1) : POS_W'(2);
        pos_delta = dir_q ? pos_mag : POS_W'(0) - pos_mag;
    end

    assign cmd_ready = (state == S_IDLE) && !reset;
    assign busy      = (state == S_RUN);

    always_ff @(posedge drv_clk) begin
        if (reset) begin
            state      <= S_IDLE;
            ph         <= '0;
            dir_q      <= 1'b0;
            half_q     <= 1'b0;
            period_q   <= '0;
            div        <= '0;
            steps_left <= '0;
            position   <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            motor_drv  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        dir_q      <= cmd_dir;
                        half_q     <= cmd_half;
                        period_q   <= cmd_period;
                        div        <= cmd_period;
                        steps_left <= cmd_steps;
                        aborted    <= 1'b0;
                        motor_drv  <= pat_of(ph);
                        if (cmd_steps == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Abort takes priority over a step due on the same edge.
                    if (abort) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                    end else if (div == '0) begin
                        ph         <= ph_next;
                        motor_drv  <= pat_of(ph_next);
                        position   <= position + pos_delta;
                        div        <= period_q;
                        steps_left <= steps_left - CNT_W'(1);
                        if (steps_left == CNT_W'(1)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        div <= div - DIV_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stepper_seq_drv.sv
// Scoreboarded bench for stepper_seq_drv (PHASES=4): every step is predicted with
// its drive pattern, position and edge number, and popped when the DUT position moves.
module tb_stepper_seq_drv;

    logic        drv_clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic        cmd_half;
    logic [7:0]  cmd_steps;
    logic [7:0]  cmd_period;
    logic        abort;
    logic [3:0]  motor_drv;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [7:0]  steps_left;
    logic [15:0] position;

    typedef struct {
        logic [3:0]  drv;
        logic [15:0] pos;
        int          cyc;
    } step_t;

    step_t       exp_q[$];
    step_t       mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          model_ph = 0;
    logic [15:0] model_pos = '0;
    logic [15:0] last_pos = '0;

    stepper_seq_drv #(.PHASES(4), .CNT_W(8), .DIV_W(8), .POS_W(16)) dut (
        .drv_clk    (drv_clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_half   (cmd_half),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .motor_drv  (motor_drv),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .steps_left (steps_left),
        .position   (position)
    );

    always #5 drv_clk = ~drv_clk;
    always @(posedge drv_clk) cyc <= cyc + 1;

    function automatic logic [3:0] exp_pat(input int p);
        logic [3:0] one;
        one = 4'b0001;
        if (p % 2 == 0) return one << (p / 2);
        return (one << ((p - 1) / 2)) | (one << (((p + 1) / 2) % 4));
    endfunction

    // Step scoreboard: any position change must match the oldest predicted step.
    always @(negedge drv_clk) begin
        if (reset === 1'b0 && position !== last_pos) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL step_unexpected: position=%h drv=%b at edge %0d, required no step", position, motor_drv, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (motor_drv !== mon_e.drv || position !== mon_e.pos || cyc !== mon_e.cyc) begin
                    n_err++;
                    $display("FAIL step: drv=%b pos=%h edge=%0d, required drv=%b pos=%h edge=%0d",
                             motor_drv, position, cyc, mon_e.drv, mon_e.pos, mon_e.cyc);
                end
            end
        end
        last_pos = position;
    end

    task automatic push_steps(input bit dir, input bit half, input int n, input int period, input int k);
        int    d;
        step_t e;
        d = half ? 1 : 2;
        for (int i = 1; i <= n; i++) begin
            model_ph  = dir ? (model_ph + d) % 8 : (model_ph + 8 - d) % 8;
            model_pos = model_pos + 16'(dir ? d : -d);
            e.drv = exp_pat(model_ph);
            e.pos = model_pos;
            e.cyc = k + i * (period + 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_cmd(input bit dir, input bit half, input int steps, input int period,
                            input int nexp, output int k);
        cmd_dir    = dir;
        cmd_half   = half;
        cmd_steps  = 8'(steps);
        cmd_period = 8'(period);
        cmd_valid  = 1'b1;
        k = cyc + 1;
        push_steps(dir, half, nexp, period, k);
        @(negedge drv_clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int d);
        d = -1;
        for (int i = 0; i < 400; i++) begin
            if (done === 1'b1) begin
                d = cyc;
                break;
            end
            @(negedge drv_clk); #1;
        end
        if (d < 0) begin
            n_vec++; n_err++;
            $display("FAIL done_timeout: no done pulse by edge %0d, required one", cyc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        cmd_dir = 1'b0; cmd_half = 1'b0; cmd_steps = '0; cmd_period = '0;
        repeat (3) @(negedge drv_clk); #1;
        n_vec++; if (motor_drv !== 4'b0000) begin n_err++; $display("FAIL rst_drv: got %b, required 0000", motor_drv); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b, required 0", done); end
        n_vec++; if (aborted !== 1'b0) begin n_err++; $display("FAIL rst_aborted: got %b, required 0", aborted); end
        n_vec++; if (position !== 16'h0000) begin n_err++; $display("FAIL rst_pos: got %h, required 0000", position); end
        n_vec++; if (steps_left !== 8'h00) begin n_err++; $display("FAIL rst_steps_left: got %h, required 00", steps_left); end
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_held: got %b, required 0", cmd_ready); end
        reset = 1'b0; #1;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_release: got %b, required 1", cmd_ready); end
        model_ph = 0; model_pos = '0;
    endtask

    task automatic test_half_rev();
        int k, d;
        send_cmd(1'b0, 1'b1, 3, 0, 3, k);
        n_vec++; if (motor_drv !== 4'b0001) begin n_err++; $display("FAIL hrev_energize: got %b, required 0001", motor_drv); end
        wait_done(d);
        n_vec++; if (d !== k + 3) begin n_err++; $display("FAIL hrev_done_edge: got %0d, required %0d", d, k + 3); end
        n_vec++; if (position !== 16'hFFFD) begin n_err++; $display("FAIL hrev_pos: got %h, required FFFD", position); end
        n_vec++; if (motor_drv !== 4'b1100) begin n_err++; $display("FAIL hrev_drv: got %b, required 1100", motor_drv); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL hrev_steps: %0d steps missing, required 0", exp_q.size()); end
        @(negedge drv_clk); #1;
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL hrev_done_width: got %b, required 0", done); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL hrev_ready: got %b, required 1", cmd_ready); end
    endtask

    task automatic test_full_fwd();
        int k, d;
        send_cmd(1'b1, 1'b0, 4, 0, 4, k);
        wait_done(d);
        n_vec++; if (d !== k + 4) begin n_err++; $display("FAIL ffwd_done_edge: got %0d, required %0d", d, k + 4); end
        n_vec++; if (position !== 16'h0005) begin n_err++; $display("FAIL ffwd_pos: got %h, required 0005", position); end
        n_vec++; if (motor_drv !== 4'b1100) begin n_err++; $display("FAIL ffwd_drv: got %b, required 1100", motor_drv); end
        n_vec++; if (steps_left !== 8'h00) begin n_err++; $display("FAIL ffwd_steps_left: got %h, required 00", steps_left); end
        @(negedge drv_clk); #1;
    endtask

    task automatic test_period();
        int k, d;
        send_cmd(1'b1, 1'b1, 2, 2, 2, k);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL per_busy: got %b, required 1", busy); end
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL per_ready: got %b, required 0", cmd_ready); end
        wait_done(d);
        n_vec++; if (d !== k + 6) begin n_err++; $display("FAIL per_done_edge: got %0d, required %0d", d, k + 6); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL per_busy_done: got %b, required 0", busy); end
        n_vec++; if (position !== 16'h0007) begin n_err++; $display("FAIL per_pos: got %h, required 0007", position); end
        @(negedge drv_clk); #1;
    endtask

    task automatic test_abort();
        int k;
        send_cmd(1'b1, 1'b0, 5, 3, 2, k);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(negedge drv_clk); #1;
        end
        n_vec++; if (cyc !== k + 8) begin n_err++; $display("FAIL abort_2nd_step_edge: got %0d, required %0d", cyc, k + 8); end
        abort = 1'b1;
        @(negedge drv_clk); #1;
        abort = 1'b0;
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL abort_done: got %b, required 1", done); end
        n_vec++; if (aborted !== 1'b1) begin n_err++; $display("FAIL abort_flag: got %b, required 1", aborted); end
        n_vec++; if (steps_left !== 8'd3) begin n_err++; $display("FAIL abort_steps_left: got %0d, required 3", steps_left); end
        n_vec++; if (position !== 16'h000B) begin n_err++; $display("FAIL abort_pos: got %h, required 000B", position); end
        repeat (6) @(negedge drv_clk);
        #1;
        n_vec++; if (aborted !== 1'b1) begin n_err++; $display("FAIL abort_hold: got %b, required 1", aborted); end
    endtask

    task automatic test_back_to_back();
        int k, d, d2;
        cmd_dir = 1'b1; cmd_half = 1'b0; cmd_steps = 8'd3; cmd_period = 8'd1; cmd_valid = 1'b1;
        k = cyc + 1;
        push_steps(1'b1, 1'b0, 3, 1, k);
        @(negedge drv_clk); #1;
        n_vec++; if (aborted !== 1'b0) begin n_err++; $display("FAIL b2b_aborted_clr: got %b, required 0", aborted); end
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_run: got %b, required 0", cmd_ready); end
        // Second command held valid during the first move; it must wait for IDLE.
        cmd_dir = 1'b0; cmd_half = 1'b1; cmd_steps = 8'd2; cmd_period = 8'd0;
        wait_done(d);
        n_vec++; if (d !== k + 6) begin n_err++; $display("FAIL b2b_done_a: got %0d, required %0d", d, k + 6); end
        push_steps(1'b0, 1'b1, 2, 0, d + 2);
        @(negedge drv_clk); #1;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_idle: got %b, required 1", cmd_ready); end
        @(negedge drv_clk); #1;
        cmd_valid = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_b: got %b, required 1", busy); end
        wait_done(d2);
        n_vec++; if (d2 !== d + 4) begin n_err++; $display("FAIL b2b_done_b: got %0d, required %0d", d2, d + 4); end
        n_vec++; if (position !== model_pos) begin n_err++; $display("FAIL b2b_pos: got %h, required %h", position, model_pos); end
        @(negedge drv_clk); #1;
    endtask

    task automatic test_reset_mid();
        int k;
        send_cmd(1'b1, 1'b0, 6, 1, 6, k);
        for (int i = 0; i < 100 && exp_q.size() > 4; i++) begin
            @(negedge drv_clk); #1;
        end
        reset = 1'b1;
        @(negedge drv_clk); #1;
        exp_q.delete();
        model_ph = 0; model_pos = '0;
        n_vec++; if (motor_drv !== 4'b0000) begin n_err++; $display("FAIL rmid_drv: got %b, required 0000", motor_drv); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b, required 0", busy); end
        n_vec++; if (position !== 16'h0000) begin n_err++; $display("FAIL rmid_pos: got %h, required 0000", position); end
        n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rmid_ready: got %b, required 0", cmd_ready); end
        reset = 1'b0; #1;
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready_rel: got %b, required 1", cmd_ready); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rmid_no_done: got %b, required 0", done); end
            @(negedge drv_clk); #1;
        end
    endtask

    task automatic test_zero_steps();
        int k;
        send_cmd(1'b1, 1'b1, 0, 5, 0, k);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b, required 1", done); end
        n_vec++; if (motor_drv !== exp_pat(model_ph)) begin n_err++; $display("FAIL zero_drv: got %b, required %b", motor_drv, exp_pat(model_ph)); end
        n_vec++; if (position !== model_pos) begin n_err++; $display("FAIL zero_pos: got %h, required %h", position, model_pos); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b, required 0", busy); end
        @(negedge drv_clk); #1;
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL zero_done_width: got %b, required 0", done); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready: got %b, required 1", cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_half_rev();
        test_full_fwd();
        test_period();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_zero_steps();
        repeat (3) @(negedge drv_clk);
        #1;
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: %0d steps outstanding, required 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish by %0t", $time);
        $fatal(1);
    end

endmodule
